psl_mmio_initiator: RTL and testbench



---
 rtl/psl_mmio_pkg.sv | 39 +++
 rtl/psl_mmio_initiator_cmd_fifo.sv | 56 +++++
 rtl/psl_mmio_initiator.sv | 212 +++++++++++++++++++++
 tb/tb_psl_mmio_initiator.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psl_mmio_pkg.sv
// Shared definitions for the PSL-side MMIO initiator: AFU register map,
// queued command layout, FSM states and parity helper.
package psl_mmio_pkg;

    localparam logic [23:0] REG_CONTROL        = 24'h00_0002;
    localparam logic [23:0] REG_THRESHOLD      = 24'h00_0003;
    localparam logic [23:0] REG_READ_BASE      = 24'h00_0004;
    localparam logic [23:0] REG_WRITE_BASE     = 24'h00_0006;
    localparam logic [23:0] REG_READS_RECEIVED = 24'h00_0008;
    localparam logic [23:0] REG_READS_WRITTEN  = 24'h00_0009;
    localparam logic [23:0] REG_NUM_ITEMS      = 24'h00_000a;
    localparam logic [23:0] REG_START          = 24'h00_0010;
    localparam logic [23:0] REG_RESET          = 24'h00_0020;
    localparam logic [23:0] REG_STATUS         = 24'h00_0030;
    localparam logic [23:0] REG_DDR3_BASE      = 24'h00_0040;

    typedef struct packed {
        logic        rnw;
        logic        dw;
        logic        afu_desc;
        logic [23:0] addr;
        logic [63:0] wdata;
    } mmio_cmd_t;

    localparam int unsigned CMD_W = $bits(mmio_cmd_t);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_RESP
    } mmio_state_e;

    // Parity bit that makes ones(v) + bit odd.
    function automatic logic odd_parity64(input logic [63:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/psl_mmio_initiator_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO for packed MMIO commands,
// with occupancy count and full/empty flags.
module psl_mmio_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 91
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A simultaneous pop frees the slot a full-queue push needs.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/psl_mmio_initiator.sv
// PSL-side MMIO initiator: queues commands, issues one access at a time
// into an AFU MMIO slave, and reports data, timeout, alignment and parity status.
module psl_mmio_initiator
    import psl_mmio_pkg::*;
#(
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          CHECK_RPAR     = 1'b0
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rnw,
    input  logic        cmd_dw,
    input  logic        cmd_afu_desc,
    input  logic [23:0] cmd_addr,
    input  logic [63:0] cmd_wdata,
    output logic        mmio_valid,
    output logic        mmio_rnw,
    output logic        mmio_dw,
    output logic        mmio_afu_desc,
    output logic [23:0] mmio_addr,
    output logic        mmio_addrpar,
    output logic [63:0] mmio_wdata,
    output logic        mmio_wpar,
    input  logic        mmio_ack,
    input  logic [63:0] mmio_rdata,
    input  logic        mmio_rpar,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        rsp_err,
    output logic        rsp_rpar_err,
    output logic        busy,
    output logic        spurious_ack
);

    localparam int unsigned CW       = $clog2(CMD_DEPTH);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    mmio_state_e r_state;
    mmio_state_e w_state_nxt;

    mmio_cmd_t   w_cmd_in;
    mmio_cmd_t   w_cmd_out;
    logic [CW:0] w_count;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_misaligned;
    logic        w_timeout_hit;
    logic [63:0] w_ack_rdata;

    logic [15:0] r_timer;
    logic        r_mmio_rnw;
    logic        r_mmio_dw;
    logic        r_mmio_afu_desc;
    logic [23:0] r_mmio_addr;
    logic [63:0] r_mmio_wdata;
    logic        r_addrpar;
    logic        r_wpar;
    logic [63:0] r_rsp_rdata;
    logic        r_rsp_timeout;
    logic        r_rsp_err;
    logic        r_rsp_rpar_err;
    logic        r_spurious;
    logic        r_armed;

    always_comb begin
        w_cmd_in          = '0;
        w_cmd_in.rnw      = cmd_rnw;
        w_cmd_in.dw       = cmd_dw;
        w_cmd_in.afu_desc = cmd_afu_desc;
        w_cmd_in.addr     = cmd_addr;
        w_cmd_in.wdata    = cmd_wdata;
    end

    assign cmd_ready = ~w_full;
    assign w_push    = cmd_valid & cmd_ready;
    assign w_pop     = (r_state == ST_IDLE) & ~w_empty;

    psl_mmio_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk     (clk),
        .rstb    (rstb),
        .i_push  (w_push),
        .i_wdata (w_cmd_in),
        .i_pop   (w_pop),
        .o_rdata (w_cmd_out),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_misaligned  = w_cmd_out.dw & w_cmd_out.addr[0];
    assign w_timeout_hit = (r_timer == TMO_LAST);

    always_comb begin
        w_ack_rdata = '0;
        if (r_mmio_rnw) begin
            w_ack_rdata = r_mmio_dw ? mmio_rdata : {32'h0, mmio_rdata[31:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:     if (w_pop) w_state_nxt = w_misaligned ? ST_RESP : ST_ISSUE;
            ST_ISSUE:    w_state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: if (mmio_ack || w_timeout_hit) w_state_nxt = ST_RESP;
            ST_RESP:     if (rsp_ready) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_timer         <= '0;
            r_mmio_rnw      <= 1'b0;
            r_mmio_dw       <= 1'b0;
            r_mmio_afu_desc <= 1'b0;
            r_mmio_addr     <= '0;
            r_mmio_wdata    <= '0;
            r_addrpar       <= 1'b0;
            r_wpar          <= 1'b0;
            r_rsp_rdata     <= '0;
            r_rsp_timeout   <= 1'b0;
            r_rsp_err       <= 1'b0;
            r_rsp_rpar_err  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    // Misaligned commands leave the bus fields untouched.
                    if (w_pop && w_misaligned) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                    end else if (w_pop) begin
                        r_mmio_rnw      <= w_cmd_out.rnw;
                        r_mmio_dw       <= w_cmd_out.dw;
                        r_mmio_afu_desc <= w_cmd_out.afu_desc;
                        r_mmio_addr     <= w_cmd_out.addr;
                        r_mmio_wdata    <= w_cmd_out.wdata;
                        r_addrpar       <= odd_parity64({40'h0, w_cmd_out.addr});
                        r_wpar          <= odd_parity64(w_cmd_out.wdata);
                    end
                end
                ST_ISSUE: r_timer <= '0;
                ST_WAIT_ACK: begin
                    r_timer <= r_timer + 16'd1;
                    if (mmio_ack) begin
                        r_rsp_rdata    <= w_ack_rdata;
                        r_rsp_rpar_err <= CHECK_RPAR & r_mmio_rnw &
                                          (mmio_rpar != odd_parity64(w_ack_rdata));
                    end else if (w_timeout_hit) begin
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= '1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_rdata    <= '0;
                        r_rsp_timeout  <= 1'b0;
                        r_rsp_err      <= 1'b0;
                        r_rsp_rpar_err <= 1'b0;
                    end
                end
                default: r_timer <= '0;
            endcase
        end
    end

    // Acks count as spurious only once an access has been issued since reset,
    // so a slave still answering a pre-reset access is ignored.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_armed    <= 1'b0;
            r_spurious <= 1'b0;
        end else begin
            if (r_state == ST_ISSUE) r_armed <= 1'b1;
            if (mmio_ack && (r_state != ST_WAIT_ACK) && (r_armed || (r_state == ST_ISSUE))) begin
                r_spurious <= 1'b1;
            end
        end
    end

    assign mmio_valid    = (r_state == ST_ISSUE);
    assign mmio_rnw      = r_mmio_rnw;
    assign mmio_dw       = r_mmio_dw;
    assign mmio_afu_desc = r_mmio_afu_desc;
    assign mmio_addr     = r_mmio_addr;
    assign mmio_addrpar  = r_addrpar;
    assign mmio_wdata    = r_mmio_wdata;
    assign mmio_wpar     = r_wpar;
    assign rsp_valid     = (r_state == ST_RESP);
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_timeout   = r_rsp_timeout;
    assign rsp_err       = r_rsp_err;
    assign rsp_rpar_err  = r_rsp_rpar_err;
    assign busy          = (w_count != '0) | (r_state != ST_IDLE);
    assign spurious_ack  = r_spurious;

endmodule

// File: tb/tb_psl_mmio_initiator.sv
// Directed + randomized bench for psl_mmio_initiator with a behavioural
// slave and a transaction-level reference model.
module tb_psl_mmio_initiator;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rstb;
    logic        cmd_valid, cmd_ready, cmd_rnw, cmd_dw, cmd_afu_desc;
    logic [23:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic        mmio_valid, mmio_rnw, mmio_dw, mmio_afu_desc, mmio_addrpar, mmio_wpar;
    logic [23:0] mmio_addr;
    logic [63:0] mmio_wdata;
    logic        mmio_ack, mmio_rpar;
    logic [63:0] mmio_rdata;
    logic        rsp_valid, rsp_ready, rsp_timeout, rsp_err, rsp_rpar_err, busy, spurious_ack;
    logic [63:0] rsp_rdata;

    always #5 clk = ~clk;

    psl_mmio_initiator #(
        .CMD_DEPTH      (4),
        .TIMEOUT_CYCLES (TMO),
        .CHECK_RPAR     (1'b1)
    ) dut (
        .clk           (clk),
        .rstb          (rstb),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_rnw       (cmd_rnw),
        .cmd_dw        (cmd_dw),
        .cmd_afu_desc  (cmd_afu_desc),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .mmio_valid    (mmio_valid),
        .mmio_rnw      (mmio_rnw),
        .mmio_dw       (mmio_dw),
        .mmio_afu_desc (mmio_afu_desc),
        .mmio_addr     (mmio_addr),
        .mmio_addrpar  (mmio_addrpar),
        .mmio_wdata    (mmio_wdata),
        .mmio_wpar     (mmio_wpar),
        .mmio_ack      (mmio_ack),
        .mmio_rdata    (mmio_rdata),
        .mmio_rpar     (mmio_rpar),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_timeout   (rsp_timeout),
        .rsp_err       (rsp_err),
        .rsp_rpar_err  (rsp_rpar_err),
        .busy          (busy),
        .spurious_ack  (spurious_ack)
    );

    // delay = cycles from mmio_valid to the slave's ack; < 1 means never.
    typedef struct {
        logic        rnw;
        logic        dw;
        logic        afu;
        logic [23:0] addr;
        logic [63:0] wdata;
        int          delay;
        logic [63:0] srdata;
        bit          badpar;
    } tcmd_t;

    typedef struct {
        logic [63:0] rdata;
        logic        to;
        logic        err;
        logic        rp;
    } trsp_t;

    int          checks = 0, failures = 0, cyc = 0;
    tcmd_t       pend[$];
    trsp_t       exp_q[$];
    tcmd_t       al_cmd [256];
    int          al_n = 0;
    int          slv_idx = 0;
    logic [2:0]  iss_attr [256];
    logic [23:0] iss_addr [256];
    logic [63:0] iss_wdata [256];
    logic        iss_apar [256];
    logic        iss_wpar [256];
    int          iss_cyc [256];
    int          n_acc = 0, acc_cyc = 0, rsp_cyc = 0;
    logic [63:0] last_rdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic oddp(input logic [63:0] v);
        return ($countones(v) % 2) == 0;
    endfunction

    function automatic tcmd_t mk(input logic rnw, input logic dw, input logic [23:0] addr,
                                 input logic [63:0] wdata, input int delay);
        tcmd_t c;
        c.rnw = rnw; c.dw = dw; c.afu = 1'b0; c.addr = addr; c.wdata = wdata;
        c.delay = delay; c.srdata = {$urandom, $urandom}; c.badpar = 1'b0;
        return c;
    endfunction

    function automatic trsp_t model(input tcmd_t c);
        trsp_t r;
        r.rdata = '0; r.to = 1'b0; r.err = 1'b0; r.rp = 1'b0;
        if (c.dw && c.addr[0]) begin
            r.err = 1'b1;
        end else if (c.delay < 1 || c.delay > TMO) begin
            r.to = 1'b1;
            r.rdata = '1;
        end else if (c.rnw) begin
            r.rdata = c.dw ? c.srdata : (c.srdata & 64'hFFFF_FFFF);
            r.rp = c.badpar;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Slave: records every issued access and acks after the command's delay.
    initial begin
        tcmd_t c;
        int k;
        logic [63:0] used;
        mmio_ack = 1'b0; mmio_rdata = '0; mmio_rpar = 1'b0;
        forever begin
            @(posedge clk); #1;
            mmio_ack = 1'b0;
            if (rstb && mmio_valid) begin
                k = slv_idx;
                iss_attr[k] = {mmio_rnw, mmio_dw, mmio_afu_desc};
                iss_addr[k] = mmio_addr; iss_wdata[k] = mmio_wdata;
                iss_apar[k] = mmio_addrpar; iss_wpar[k] = mmio_wpar;
                iss_cyc[k] = cyc;
                slv_idx = slv_idx + 1;
                c = al_cmd[k];
                if (c.delay >= 1) begin
                    repeat (c.delay) begin @(posedge clk); #1; end
                    used = c.dw ? c.srdata : (c.srdata & 64'hFFFF_FFFF);
                    mmio_ack = 1'b1;
                    mmio_rdata = c.srdata;
                    mmio_rpar = oddp(used) ^ c.badpar;
                end
            end
        end
    end

    task automatic offer_step(input bit rdy);
        tcmd_t t;
        trsp_t e;
        cmd_valid = (pend.size() > 0);
        if (cmd_valid) begin
            t = pend[0];
            cmd_rnw = t.rnw; cmd_dw = t.dw; cmd_afu_desc = t.afu;
            cmd_addr = t.addr; cmd_wdata = t.wdata;
        end
        rsp_ready = rdy;
        if (rsp_valid && rsp_ready) begin
            rsp_cyc = cyc;
            last_rdata = rsp_rdata;
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", rsp_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_flags", {rsp_timeout, rsp_err, rsp_rpar_err}, {e.to, e.err, e.rp});
                if (!e.err) chk("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
        if (cmd_valid && cmd_ready) begin
            t = pend.pop_front();
            n_acc++;
            acc_cyc = cyc;
            exp_q.push_back(model(t));
            if (!(t.dw && t.addr[0])) begin
                al_cmd[al_n] = t;
                al_n++;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run(input int budget, input bit rand_rdy);
        int c = 0;
        while ((pend.size() > 0 || exp_q.size() > 0) && c < budget) begin
            offer_step(rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            c++;
        end
        rsp_ready = 1'b0;
        chk("run_budget", pend.size() + exp_q.size(), 0);
    endtask

    task automatic check_issues(input int from);
        chk("issue_count", slv_idx, al_n);
        for (int k = from; k < slv_idx && k < al_n; k++) begin
            chk("iss_attr", iss_attr[k], {al_cmd[k].rnw, al_cmd[k].dw, al_cmd[k].afu});
            chk("iss_addr", iss_addr[k], al_cmd[k].addr);
            chk("iss_wdata", iss_wdata[k], al_cmd[k].wdata);
            chk("iss_addrpar", iss_apar[k], oddp({40'h0, al_cmd[k].addr}));
            chk("iss_wpar", iss_wpar[k], oddp(al_cmd[k].wdata));
        end
    endtask

    initial begin
        int base, acc0;
        tcmd_t t;
        logic [63:0] rd64;
        rstb = 1'b0; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_dw = 1'b0; cmd_afu_desc = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", {cmd_ready, busy, mmio_valid, mmio_rnw, mmio_dw, mmio_afu_desc, mmio_addrpar,
                          mmio_wpar, rsp_valid, rsp_timeout, rsp_err, rsp_rpar_err, spurious_ack}, 13'h1000);
        chk("rst_addr", mmio_addr, 0);
        chk("rst_wdata", mmio_wdata, 0);
        chk("rst_rdata", rsp_rdata, 0);
        rstb = 1'b1;
        @(posedge clk); #1;

        // Write to CONTROL, ack 2 cycles after the strobe.
        base = slv_idx;
        pend.push_back(mk(1'b0, 1'b0, 24'h2, 64'h0000_0000_8000_0C05, 2));
        run(40, 1'b0);
        check_issues(base);
        chk("wr_issue_lat", iss_cyc[base] - acc_cyc, 2);
        chk("wr_rsp_lat", rsp_cyc - iss_cyc[base], 3);
        chk("wr_addrpar", iss_apar[base], 0);
        chk("wr_wpar", iss_wpar[base], 0);

        // 32-bit read of STATUS, then 64-bit read of READ_BASE.
        base = slv_idx;
        t = mk(1'b1, 1'b0, 24'h30, 64'h0, 3);
        t.srdata = 64'h0000_0003_0000_0003;
        pend.push_back(t);
        run(40, 1'b0);
        chk("rd32_rdata", last_rdata, 64'h3);
        rd64 = {$urandom, $urandom};
        t = mk(1'b1, 1'b1, 24'h4, 64'h0, 2);
        t.srdata = rd64;
        pend.push_back(t);
        run(40, 1'b0);
        chk("rd64_rdata", last_rdata, rd64);
        check_issues(base);

        // Ack on the last cycle before timeout still wins; bad parity on a write never flags.
        base = slv_idx;
        pend.push_back(mk(1'b1, 1'b1, 24'h40, 64'h0, TMO));
        run(60, 1'b0);
        chk("ack_tie_lat", rsp_cyc - iss_cyc[base], TMO + 1);
        t = mk(1'b0, 1'b0, 24'h3, {$urandom, $urandom}, 1);
        t.badpar = 1'b1;
        pend.push_back(t);
        t = mk(1'b1, 1'b0, 24'h8, 64'h0, 2);
        t.badpar = 1'b1;
        pend.push_back(t);
        run(60, 1'b0);
        check_issues(base);

        // Randomized traffic with random response backpressure.
        base = slv_idx;
        for (int i = 0; i < 24; i++) begin
            t = mk(1'($urandom), 1'($urandom), 24'($urandom), {$urandom, $urandom},
                   int'($urandom_range(1, TMO)));
            t.afu = 1'($urandom);
            t.badpar = ($urandom_range(0, 3) == 0);
            pend.push_back(t);
        end
        run(3000, 1'b1);
        check_issues(base);
        chk("no_spurious", spurious_ack, 0);

        // Misaligned 64-bit read is rejected; the next command issues normally.
        base = slv_idx;
        pend.push_back(mk(1'b1, 1'b1, 24'h5, 64'h0, 2));
        pend.push_back(mk(1'b0, 1'b0, 24'h10, 64'h1, 2));
        run(60, 1'b0);
        chk("misalign_issues", slv_idx - base, 1);
        check_issues(base);

        // Response backpressure with six back-to-back commands.
        base = slv_idx;
        acc0 = n_acc;
        for (int i = 0; i < 6; i++) pend.push_back(mk(1'b0, 1'b1, 24'h100 + 24'(2 * i), {$urandom, $urandom}, 2));
        for (int i = 0; i < 12; i++) offer_step(1'b0);
        chk("bp_accepted", n_acc - acc0, 5);
        chk("bp_cmd_ready", cmd_ready, 0);
        chk("bp_rsp_busy", {rsp_valid, busy}, 2'b11);
        chk("bp_issued", slv_idx - base, 1);
        run(200, 1'b0);
        check_issues(base);

        // Timeout, then the slave's late ack 4 cycles after the abandon point.
        base = slv_idx;
        pend.push_back(mk(1'b1, 1'b0, 24'h9, 64'h0, TMO + 4));
        run(100, 1'b0);
        chk("tmo_lat", rsp_cyc - iss_cyc[base], TMO + 1);
        chk("tmo_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 10; i++) offer_step(1'b1);
        chk("late_ack_spurious", spurious_ack, 1);
        check_issues(base);

        // Reset mid-WAIT_ACK with two commands queued.
        base = slv_idx;
        for (int i = 0; i < 3; i++) pend.push_back(mk(1'b1, 1'b1, 24'h20 + 24'(2 * i), 64'h0, 10));
        for (int i = 0; i < 5; i++) offer_step(1'b1);
        chk("rst_mid_pre", {busy, mmio_valid, slv_idx - base == 1}, 3'b101);
        rstb = 1'b0;
        @(posedge clk); #1;
        rstb = 1'b1;
        chk("rst_mid_flags", {cmd_ready, busy, mmio_valid, mmio_rnw, mmio_dw, mmio_afu_desc, mmio_addrpar,
                              mmio_wpar, rsp_valid, rsp_timeout, rsp_err, rsp_rpar_err, spurious_ack}, 13'h1000);
        chk("rst_mid_rdata", rsp_rdata, 0);
        exp_q.delete();
        pend.delete();
        al_n = slv_idx;
        for (int i = 0; i < 15; i++) offer_step(1'b1);
        chk("rst_mid_no_issue", slv_idx, al_n);
        chk("rst_mid_ack_ignored", spurious_ack, 0);

        base = slv_idx;
        pend.push_back(mk(1'b1, 1'b0, 24'h3, 64'h0, 2));
        run(40, 1'b0);
        check_issues(base);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
